// File: rtl/fft_stage_sequencer.sv
// Stage/butterfly sequencer for a radix-2 FFT with run-time transform size.
// Counts butterflies per stage and stages per transform, and derives the twiddle ROM address.
//
// state | meaning
// IDLE  | waiting for start; counters hold their last values
// RUN   | counting butterfly strobes through each stage
// DONE  | single cycle carrying fft_done and the last stage_done
module fft_stage_sequencer #(
    parameter int LOG2_MAX = 8,
    parameter int SW       = $clog2(LOG2_MAX + 1),
    parameter int BW       = LOG2_MAX - 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [SW-1:0] cfg_log2,
    input  logic          bfly_strobe,
    output logic          busy,
    output logic [SW-1:0] stage_count_out,
    output logic [BW-1:0] bfly_count_out,
    output logic [BW-1:0] tw_addr,
    output logic          stage_done,
    output logic          fft_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [BW:0] ONE_EXT = {{BW{1'b0}}, 1'b1};

    state_t        state;
    logic [SW-1:0] log2_len;
    logic [SW-1:0] stage_cnt;
    logic [BW-1:0] bfly_cnt;

    logic [SW-1:0] cfg_clamped;
    logic [SW-1:0] last_stage;
    logic [SW-1:0] tw_shift;
    logic [BW:0]   half_len;
    logic [BW-1:0] bfly_mask;
    logic          last_bfly;
    logic          stage_at_last;

    always_comb begin
        if (cfg_log2 < SW'(2)) begin
            cfg_clamped = SW'(2);
        end else if (cfg_log2 > SW'(LOG2_MAX)) begin
            cfg_clamped = SW'(LOG2_MAX);
        end else begin
            cfg_clamped = cfg_log2;
        end
    end

    // Butterflies per stage is 2^(L-1); its mask doubles as the last-butterfly index
    // and as the truncation to L-1 bits for the twiddle address.
    assign last_stage    = log2_len - SW'(1);
    assign half_len      = ONE_EXT << last_stage;
    assign bfly_mask     = BW'(half_len - ONE_EXT);
    assign last_bfly     = (bfly_cnt == bfly_mask);
    assign stage_at_last = (stage_cnt == last_stage);

    assign tw_shift = last_stage - stage_cnt;
    assign tw_addr  = (bfly_cnt << tw_shift) & bfly_mask;

    assign stage_count_out = stage_cnt;
    assign bfly_count_out  = bfly_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            log2_len   <= SW'(2);
            stage_cnt  <= '0;
            bfly_cnt   <= '0;
            busy       <= 1'b0;
            stage_done <= 1'b0;
            fft_done   <= 1'b0;
        end else begin
            stage_done <= 1'b0;
            fft_done   <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                stage_cnt <= '0;
                bfly_cnt  <= '0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state     <= RUN;
                            log2_len  <= cfg_clamped;
                            stage_cnt <= '0;
                            bfly_cnt  <= '0;
                            busy      <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (bfly_strobe) begin
                            if (last_bfly) begin
                                bfly_cnt   <= '0;
                                stage_done <= 1'b1;
                                if (stage_at_last) begin
                                    state    <= DONE;
                                    busy     <= 1'b0;
                                    fft_done <= 1'b1;
                                end else begin
                                    stage_cnt <= stage_cnt + SW'(1);
                                end
                            end else begin
                                bfly_cnt <= bfly_cnt + BW'(1);
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/fft_stage_sequencer.md
# fft_stage_sequencer

Parametrised stage/butterfly sequencer for the radix-2 FFT datapath, generalising the fixed 8-stage counter to run-time-selectable transform sizes up to 2^LOG2_MAX points. It counts butterfly strobes within each stage and stages within a transform, and issues `stage_done` and `fft_done` pulses. It also generates the per-butterfly twiddle ROM address. It sits between the FFT control FSM (start/abort, butterfly strobes) and the address generator / twiddle ROM.

## Interface
- LOG2_MAX, default 8: maximum log2 of transform size (8 = 256-point); legal range 2..12.
- SW, default $clog2(LOG2_MAX+1): stage counter width (4 for default).
- BW, default LOG2_MAX-1: butterfly index / twiddle address width (7 for default).

- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a transform; honoured only in IDLE.
- abort  in  1  terminate immediately, return to IDLE.
- cfg_log2  in  SW  log2 of transform size, sampled on accepted start.
- bfly_strobe  in  1  one butterfly completed this cycle.
- busy  out  1  high in RUN.
- stage_count_out  out  SW  current stage, 0-based.
- bfly_count_out  out  BW  butterfly index within current stage.
- tw_addr  out  BW  twiddle ROM address for current butterfly.
- stage_done  out  1  one-cycle pulse: a stage just completed.
- fft_done  out  1  one-cycle pulse: transform complete.

## Operation
- FSM states IDLE, RUN, DONE. Reset → IDLE.
- IDLE: start=1 and abort=0 → RUN; latch L = clamp(cfg_log2, 2, LOG2_MAX) (0/1 → 2, >LOG2_MAX → LOG2_MAX); clear counters. bfly_strobe ignored.
- RUN: bfly_strobe increments bfly_count. Last butterfly of stage is bfly_count = 2^(L-1)-1. On strobe at last butterfly: bfly_count → 0; if stage_count < L-1, stage_count increments; else → DONE, stage_count held.
- DONE: one cycle; → IDLE unconditionally. start and bfly_strobe ignored.
- abort=1 in any state: → IDLE next edge, counters cleared, no done pulses. abort beats start and bfly_strobe in the same cycle.
- Twiddle: tw_addr = (bfly_count << (L-1-stage_count)) truncated to L-1 bits, zero-extended to BW. Computed combinationally from registered counters. Stage 0 always gives 0; last stage gives bfly_count.
- Counters are unsigned and never wrap past their terminal values. stage_count never exceeds L-1.
- A latched L holds for the whole transform; cfg_log2 changes during RUN have no effect.

## Timing
- Reset values: busy=0, stage_count_out=0, bfly_count_out=0, tw_addr=0, stage_done=0, fft_done=0, FSM=IDLE.
- busy is high the cycle after an accepted start; counters read 0 that cycle.
- stage_done is registered: high for exactly the one cycle after the edge that consumed the stage's last strobe. It fires for every stage including the last. Count is L pulses per transform.
- fft_done is high for the one DONE cycle. This is the same cycle as the final stage_done; busy is 0 that cycle.
- Counter update latency: 1 cycle after strobe. Back-to-back strobes every cycle are supported. Minimum transform time = L·2^(L-1) strobes + 1 cycle.
- A start in the cycle after DONE (i.e. in IDLE) is accepted. No dead cycle beyond DONE.
- reset mid-RUN behaves like abort (synchronous, next edge).

## Test plan
- Default config, cfg_log2=8, start, 1024 back-to-back strobes → 8 stage_done pulses, each after every 128th strobe. fft_done plus final stage_done one cycle after strobe 1024. busy deasserts that cycle. Counters end at stage 7, bfly 0.
- cfg_log2=3 → 3 stages × 4 strobes. tw_addr sequence is stage0: 0,0,0,0; stage1: 0,2,0,2; stage2: 0,1,2,3.
- Clamping: cfg_log2=0 → behaves as L=2 (2 stages × 2 strobes). cfg_log2=15 with LOG2_MAX=8 → behaves as L=8.
- Abort at stage 3, bfly 50, with start and bfly_strobe also high → next cycle IDLE, all counters 0, no stage_done/fft_done. A subsequent start runs a clean transform.
- Gapped strobes (random 0–3 idle cycles), start pulses during RUN/DONE, strobes in IDLE → counts unaffected by ignored inputs. Done pulses are still exactly one cycle.
- reset asserted mid-stage for one cycle → all outputs at reset values on the next cycle. start on the following cycle is accepted.
